robs_control: RTL and testbench
===============================

// Module: robs_control
// PURPOSE
//  Control unit (FSM) for signed Robertson's multiplication. It sits beside the robs datapath: it drives the
//  15-bit control word c[14:0] and consumes the status flags zr (R even) and zq (counter divisible by 8).
//  It sequences load, add/subtract, arithmetic-shift and write-back steps until {A,X} holds the 2*WIDTH product.
// PARAMETERS
//  WIDTH  8  operand width (must match datapath); zq cross-check valid only for WIDTH=8
//  CNTW   $clog2(WIDTH+1)  width of internal iteration counter cnt
// PORTS
//  clk      in   1   rising-edge clock
//  reset    in   1   asynchronous, active-high; forces IDLE
//  start    in   1   request multiply; sampled only in IDLE
//  zr       in   1   datapath R LSB == 0 (current multiplier bit is 0)
//  zq       in   1   datapath down-counter q % 8 == 0
//  c        out  15  control word to datapath (bit map below)
//  busy     out  1   high in every state except IDLE
//  done     out  1   one-cycle pulse in DONE; product valid from this cycle until next start
//  seq_err  out  1   sticky: zq disagreed with internal cnt; cleared by reset or accepted start
// BEHAVIOUR
//  c map: 0 ldY, 1 q reset (q<=0), 2 clrA, 3 ldX, 5:4 RH sel (00 A, 01 SR hi, 10 ALU),
//   6 RL sel (0 X, 1 SR lo), 7 X sel (0 multiplier, 1 R lo), 8 ldRH, 9 ldRL, 10 ALU (1 add, 0 sub),
//   11 shift mode (1 arithmetic), 12 shift en, 13 q decrement, 14 ldA.
//  c is a pure Moore decode of state; unlisted bits are 0 in every state.
//  Reset: state=IDLE, cnt=0, c=0, busy=0, done=0, seq_err=0.
//  States, with asserted c bits and next state:
//   IDLE  c=0. start=1 -> LOAD; else stay.
//   LOAD  c0,c1,c2,c3 (c7=0). Loads Y and X, clears A, resets q; cnt<=0; seq_err<=0 -> XFER.
//   XFER  c5:4=00, c6=0, c8, c9. Copies {A,X} into R -> TEST.
//   TEST  c=0. cnt==WIDTH -> WB; else zr=1 -> SHIFT; else cnt==WIDTH-1 -> SUB; else -> ADD.
//   ADD   c5:4=10, c10=1, c8. RH <= RH+Y -> SHIFT.
//   SUB   c5:4=10, c10=0, c8. RH <= RH-Y (sign-bit correction) -> SHIFT.
//   SHIFT c11, c12. Captures R>>>1 in the shift register -> LDSH.
//   LDSH  c5:4=01, c6, c8, c9, c13. R <= shifted value; q decrements; cnt<=cnt+1 -> TEST.
//   WB    c3, c7, c14. A <= RH, X <= RL -> DONE.
//   DONE  done=1 -> IDLE.
//  Latency: the start-sample edge is cycle 0. done is high in cycle 5+3*WIDTH+k,
//   where k = number of 1 bits in the multiplier (one ADD or SUB per set bit). WIDTH=8: 29..37.
//  zq check (WIDTH=8): in TEST with cnt>0, set seq_err if zq != (cnt==WIDTH). Sequencing never depends on zq.
//  start while busy is ignored; it is not queued. start held high through DONE begins a new op from IDLE.
//  Reset mid-operation returns to IDLE at once, with c=0; {A,X} contents are undefined until the next done.
//  Multiplier MSB=1 always takes SUB on the final iteration (two's-complement weight of -2^(WIDTH-1)).
// TESTING (bench instantiates robs_control with the robs datapath, WIDTH=8)
//  7 x 3: start pulse -> done at cycle 31, product=16'h0015, seq_err=0.
//  mult=-3 (8'hFD), mcand=5 -> done at cycle 36, product=16'hFFF1; SUB state visited exactly once.
//  mult=-128, mcand=-128 -> product=16'h4000; mult=0, mcand=8'h7F -> done at cycle 29, product=0.
//  Assert reset at cycle 12 of an op -> IDLE next edge, c=0, busy=0; next start gives a correct product.
//  Pulse start during busy -> ignored, single done; force zq=0 throughout -> seq_err=1 at final TEST, product still correct.
//  Per-state check: c matches the table in every state; done is a single-cycle pulse; busy=0 only in IDLE.

Source files
------------

// File: rtl/robs_control.sv
// Control FSM for signed Robertson multiplication: sequences the robs datapath
// through load, add/subtract, arithmetic shift and write-back of {A,X}.
module robs_control #(
    parameter int unsigned WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        zr,
    input  logic        zq,
    output logic [14:0] c,
    output logic        busy,
    output logic        done,
    output logic        seq_err
);

    localparam int unsigned CNTW = $clog2(WIDTH + 1);
    localparam int unsigned CW   = 15;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH);
    localparam logic [CNTW-1:0] CNT_PEN  = CNTW'(WIDTH - 1);

    // Control words per state (bit map: 0 ldY, 1 qrst, 2 clrA, 3 ldX, 5:4 RH sel,
    // 6 RL sel, 7 X sel, 8 ldRH, 9 ldRL, 10 add, 11 arith, 12 shift en, 13 qdec, 14 ldA)
    localparam logic [CW-1:0] C_LOAD  = 15'h000F;
    localparam logic [CW-1:0] C_XFER  = 15'h0300;
    localparam logic [CW-1:0] C_ADD   = 15'h0520;
    localparam logic [CW-1:0] C_SUB   = 15'h0120;
    localparam logic [CW-1:0] C_SHIFT = 15'h1800;
    localparam logic [CW-1:0] C_LDSH  = 15'h2350;
    localparam logic [CW-1:0] C_WB    = 15'h4088;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        XFER,
        TEST,
        ADD,
        SUB,
        SHIFT,
        LDSH,
        WB,
        DONE
    } state_t;

    state_t          state, state_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic [CW-1:0]   c_nxt;
    logic            busy_nxt;
    logic            done_nxt;
    logic            seq_err_nxt;

    // State, counter and registered Moore outputs (decoded from the next state so c tracks state)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            c       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            c       <= c_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            seq_err <= seq_err_nxt;
        end
    end

    // Next-state, counter, zq cross-check and output decode
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        seq_err_nxt = seq_err;
        c_nxt       = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = LOAD;
                    seq_err_nxt = 1'b0;
                end
            end
            LOAD: begin
                cnt_nxt     = '0;
                seq_err_nxt = 1'b0;
                state_nxt   = XFER;
            end
            XFER:  state_nxt = TEST;
            TEST: begin
                // zq is only cross-checked; sequencing runs on cnt alone
                if ((cnt != '0) && (zq != (cnt == CNT_LAST))) begin
                    seq_err_nxt = 1'b1;
                end
                if (cnt == CNT_LAST) begin
                    state_nxt = WB;
                end else if (zr) begin
                    state_nxt = SHIFT;
                end else if (cnt == CNT_PEN) begin
                    state_nxt = SUB;
                end else begin
                    state_nxt = ADD;
                end
            end
            ADD:   state_nxt = SHIFT;
            SUB:   state_nxt = SHIFT;
            SHIFT: state_nxt = LDSH;
            LDSH: begin
                cnt_nxt   = cnt + CNTW'(1);
                state_nxt = TEST;
            end
            WB:    state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        case (state_nxt)
            LOAD:    c_nxt = C_LOAD;
            XFER:    c_nxt = C_XFER;
            ADD:     c_nxt = C_ADD;
            SUB:     c_nxt = C_SUB;
            SHIFT:   c_nxt = C_SHIFT;
            LDSH:    c_nxt = C_LDSH;
            WB:      c_nxt = C_WB;
            default: c_nxt = '0;
        endcase

        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_robs_control.sv
// Bench for robs_control: a small behavioural robs datapath driven by c, directed operations.
module tb_robs_control;

    localparam logic [14:0] E_LOAD  = 15'h000F;
    localparam logic [14:0] E_XFER  = 15'h0300;
    localparam logic [14:0] E_TEST  = 15'h0000;
    localparam logic [14:0] E_ADD   = 15'h0520;
    localparam logic [14:0] E_SUB   = 15'h0120;
    localparam logic [14:0] E_SHIFT = 15'h1800;
    localparam logic [14:0] E_LDSH  = 15'h2350;
    localparam logic [14:0] E_WB    = 15'h4088;
    localparam logic [14:0] E_DONE  = 15'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        zr;
    logic        zq;
    logic [14:0] c;
    logic        busy;
    logic        done;
    logic        seq_err;

    int total = 0;
    int bad   = 0;

    // datapath model
    logic [7:0]  mult_in, mcand_in;
    logic [7:0]  ya, aa, xa;
    logic [8:0]  rh;
    logic [7:0]  rl;
    logic [16:0] sr;
    logic [2:0]  q;
    logic [8:0]  alu;
    logic        zq_force;

    robs_control #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .zr      (zr),
        .zq      (zq),
        .c       (c),
        .busy    (busy),
        .done    (done),
        .seq_err (seq_err)
    );

    always #5 clk = ~clk;

    assign alu = c[10] ? (rh + {ya[7], ya}) : (rh - {ya[7], ya});
    assign zr  = ~rl[0];
    assign zq  = zq_force ? 1'b0 : (q == 3'd0);

    // Datapath registers under control of c (RH carries an extra sign bit)
    always @(posedge clk) begin
        if (c[0]) ya <= mcand_in;
        if (c[1]) q <= 3'd0;
        else if (c[13]) q <= q - 3'd1;
        if (c[2]) aa <= 8'd0;
        else if (c[14]) aa <= rh[7:0];
        if (c[3]) xa <= c[7] ? rl : mult_in;
        if (c[8]) begin
            case (c[5:4])
                2'b00:   rh <= {aa[7], aa};
                2'b01:   rh <= sr[16:8];
                default: rh <= alu;
            endcase
        end
        if (c[9]) rl <= c[6] ? sr[7:0] : xa;
        if (c[12]) begin
            if (c[11]) sr <= 17'($signed({rh, rl}) >>> 1);
            else       sr <= {rh, rl} >> 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One multiply: per-cycle c/busy/done against the state sequence implied by the multiplier bits
    task automatic run_op(input logic [7:0] m, input logic [7:0] y, input logic [15:0] exp_p,
                          input int exp_cyc, input int pulse_at, input logic exp_serr);
        logic [14:0] seq[$];
        int done_cyc;
        int subs;
        seq.push_back(E_LOAD);
        seq.push_back(E_XFER);
        for (int i = 0; i < 8; i++) begin
            seq.push_back(E_TEST);
            if (m[i]) seq.push_back((i == 7) ? E_SUB : E_ADD);
            seq.push_back(E_SHIFT);
            seq.push_back(E_LDSH);
        end
        seq.push_back(E_TEST);
        seq.push_back(E_WB);
        seq.push_back(E_DONE);

        done_cyc = -1;
        subs     = 0;
        mult_in  = m;
        mcand_in = y;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < seq.size(); i++) begin
            chk($sformatf("c@%0d", i + 1), 32'(c), 32'(seq[i]));
            chk($sformatf("busy@%0d", i + 1), 32'(busy), 32'd1);
            chk($sformatf("done@%0d", i + 1), 32'(done), 32'(i == seq.size() - 1));
            if (i == 0) chk("seq_err_clr", 32'(seq_err), 32'd0);
            if (c == E_SUB) subs++;
            if (done) done_cyc = i + 1;
            start = ((i + 1) == pulse_at);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_c", 32'(c), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("done_cycle", 32'(done_cyc), 32'(exp_cyc));
        chk("product", 32'({aa, xa}), 32'(exp_p));
        chk("seq_err", 32'(seq_err), 32'(exp_serr));
        chk("sub_visits", 32'(subs), 32'(m[7]));
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_extra_done", 32'(done), 32'd0);
            chk("stay_idle", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        zq_force = 1'b0;
        mult_in  = 8'd0;
        mcand_in = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_c", 32'(c), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_seq_err", 32'(seq_err), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_start", 32'(busy), 32'd0);

        // 7 x 3
        run_op(8'd3, 8'd7, 16'h0015, 31, 0, 1'b0);
        // -3 x 5
        run_op(8'hFD, 8'd5, 16'hFFF1, 36, 0, 1'b0);
        // -128 x -128
        run_op(8'h80, 8'h80, 16'h4000, 30, 0, 1'b0);
        // 0 x 127
        run_op(8'h00, 8'h7F, 16'h0000, 29, 0, 1'b0);
        // 11 x -10, start pulsed while busy
        run_op(8'h0B, 8'hF6, 16'hFF92, 32, 10, 1'b0);
        // -127 x 3 with zq stuck low
        zq_force = 1'b1;
        run_op(8'h81, 8'h03, 16'hFE83, 31, 0, 1'b1);
        zq_force = 1'b0;

        // reset in cycle 12 of an operation
        mult_in  = 8'd3;
        mcand_in = 8'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_c", 32'(c), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_seq_err", 32'(seq_err), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("postrst_idle", 32'(busy), 32'd0);
        // after zq fault run, the clean op must also report seq_err=0
        run_op(8'hFD, 8'd5, 16'hFFF1, 36, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
